demux32_stream: RTL and testbench
=================================

Name: demux32_stream

Overview:
- 1:2 stream demultiplexer: the steering counterpart of the 2:1 datapath muxes.
- Takes one WIDTH-bit source with a valid/ready handshake and routes each accepted word to one of two destinations (dout_1 or dout_0), chosen by select.
- Each destination has its own small FIFO, so one stalled consumer does not corrupt the other's data.
- Sits between a single producer (e.g. a result/write-back source) and two consumers in the processor datapath.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.
- CW, 2, occupancy counter width; must satisfy 2^CW > DEPTH (CW = log2(DEPTH)+1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- din  input  WIDTH  source data.
- din_valid  input  1  source has a word.
- din_ready  output  1  block accepts din this cycle.
- select  input  1  destination of the current word: 1 -> dout_1, 0 -> dout_0.
- dout_1  output  WIDTH  head of FIFO 1.
- dout_1_valid  output  1  FIFO 1 non-empty.
- dout_1_ready  input  1  consumer 1 takes its head.
- dout_0  output  WIDTH  head of FIFO 0.
- dout_0_valid  output  1  FIFO 0 non-empty.
- dout_0_ready  input  1  consumer 0 takes its head.
- count_1  output  CW  occupancy of FIFO 1.
- count_0  output  CW  occupancy of FIFO 0.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-high (reset); all state is cleared immediately on assertion, independent of clk.
- Reset values:
  - dout_1 = dout_0 = 0; dout_1_valid = dout_0_valid = 0.
  - count_1 = count_0 = 0.
  - Read/write pointers = 0.
  - din_ready = 1 once reset deasserts.
- Reset mid-operation: all buffered words are discarded, no output handshake occurs, and the block restarts empty.
- Accept: a word is accepted on a rising edge when din_valid=1 and din_ready=1. select is sampled only on that edge; it is ignored at all other times.
- din_ready: combinational, = !full(selected FIFO), where full means count == DEPTH.
  - din_ready does not depend on dout_x_ready. A full FIFO refuses a push even if it pops in the same cycle.
  - din_ready may fall and rise with select while din_valid is held.
- Push: the accepted word is written at the write pointer of FIFO[select], and that write pointer increments modulo DEPTH.
- Pop: on an edge where dout_x_valid=1 and dout_x_ready=1, FIFO x's read pointer increments modulo DEPTH. dout_x_ready while dout_x_valid=0 has no effect.
- Output data: dout_x = mem_x[rd_ptr_x] whenever count_x != 0, and 0 when count_x == 0. dout_x_valid = (count_x != 0).
- Latency: a word accepted at edge N into an empty FIFO appears on dout_x with dout_x_valid=1 after edge N, i.e. one cycle later. There is no fall-through in the same cycle.
- Occupancy arithmetic: count_x' = count_x + push_x − pop_x.
  - Push and pop on the same edge leave count unchanged and move both pointers.
  - count never exceeds DEPTH and never underflows.
- Ordering: strict FIFO order per destination. There is no ordering relation between the two destinations.
- Independence: both FIFOs may pop on the same edge. A push targets exactly one FIFO; the other FIFO is untouched except for its own pop.
- Pointer wrap: pointers wrap from DEPTH−1 to 0 silently.
- No state machine beyond the per-FIFO pointers and counters. No error outputs: illegal conditions are unreachable by construction.

Test Plan:
- Reset check: assert reset mid-cycle with no clock edge -> all outputs go to 0 at once (async). Deassert -> din_ready=1, counts 0.
- Steering and latency: push 0xAAAA_0001 with select=1, then 0x5555_0000 with select=0, both consumers ready=0. Required response:
  - dout_1=0xAAAA_0001 with valid the cycle after its accept.
  - dout_0=0x5555_0000 with valid the cycle after its accept.
  - count_1=1, count_0=1.
- Full back-pressure: select=1, dout_1_ready=0, push 0x10, 0x11, then 0x12. Required response:
  - count_1=2 and din_ready=0 while select=1.
  - Switching select=0 -> din_ready=1, and 0x12 lands in FIFO 0.
  - Raising dout_1_ready pops 0x10 then 0x11 in order.
- Simultaneous push/pop: FIFO 0 holds 1 word (0x20), dout_0_ready=1, push 0x21 with select=0 -> next cycle count_0 stays 1 and dout_0=0x21.
- Wrap-around: stream 10 words 0x30..0x39 to FIFO 1 with dout_1_ready=1 throughout -> words emerge 0x30..0x39 in order and count_1 never exceeds 1.
- Reset mid-stream: FIFO 1 holds 2 words, FIFO 0 holds 1 word, then assert reset -> counts 0, valids 0, and no stale data appears after release.

Source files
------------

// File: rtl/demux32_stream.sv
// 1:2 stream demultiplexer: one valid/ready source steered by select into
// two independent per-destination FIFOs.
module demux32_stream #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             select,
    output logic [WIDTH-1:0] dout_1,
    output logic             dout_1_valid,
    input  logic             dout_1_ready,
    output logic [WIDTH-1:0] dout_0,
    output logic             dout_0_valid,
    input  logic             dout_0_ready,
    output logic [CW-1:0]    count_1,
    output logic [CW-1:0]    count_0
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q    [2][DEPTH];
    logic [WIDTH-1:0] mem_d    [2][DEPTH];
    logic [PW-1:0]    wr_ptr_q [2];
    logic [PW-1:0]    wr_ptr_d [2];
    logic [PW-1:0]    rd_ptr_q [2];
    logic [PW-1:0]    rd_ptr_d [2];
    logic [CW-1:0]    count_q  [2];
    logic [CW-1:0]    count_d  [2];
    logic [WIDTH-1:0] dout     [2];
    logic [1:0]       rdy;
    logic [1:0]       push;
    logic [1:0]       pop;

    assign rdy = {dout_1_ready, dout_0_ready};

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push     = '0;
        pop      = '0;
        // A full FIFO refuses a push even if it drains on the same edge
        din_ready = (count_q[select] != FULL);
        for (int i = 0; i < 2; i++) begin
            push[i] = din_valid && din_ready && (select == 1'(i));
            pop[i]  = (count_q[i] != '0) && rdy[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = din;
                wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            end
            count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
            dout[i] = (count_q[i] != '0) ? mem_q[i][rd_ptr_q[i]] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout_1       = dout[1];
    assign dout_0       = dout[0];
    assign dout_1_valid = (count_q[1] != '0);
    assign dout_0_valid = (count_q[0] != '0);
    assign count_1      = count_q[1];
    assign count_0      = count_q[0];

endmodule

// File: tb/tb_demux32_stream.sv
// Self-checking bench for demux32_stream: per-destination expected-data
// queues filled on accept and drained on output handshake.
module tb_demux32_stream;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             select;
    logic [WIDTH-1:0] dout_1;
    logic             dout_1_valid;
    logic             dout_1_ready;
    logic [WIDTH-1:0] dout_0;
    logic             dout_0_valid;
    logic             dout_0_ready;
    logic [CW-1:0]    count_1;
    logic [CW-1:0]    count_0;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp1[$];
    logic [WIDTH-1:0] exp0[$];

    demux32_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .select(select),
        .dout_1(dout_1),
        .dout_1_valid(dout_1_valid),
        .dout_1_ready(dout_1_ready),
        .dout_0(dout_0),
        .dout_0_valid(dout_0_valid),
        .dout_0_ready(dout_0_ready),
        .count_1(count_1),
        .count_0(count_0)
    );

    always #5 clk = ~clk;

    // Called just after an edge with inputs set; scores this cycle's
    // handshakes before the next edge, then advances one cycle.
    task automatic step();
        logic [WIDTH-1:0] e;
        #1;
        if (!reset) begin
            if (dout_1_valid && dout_1_ready) begin
                checks++;
                if (exp1.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop1 got %h expected nothing", dout_1);
                end else begin
                    e = exp1.pop_front();
                    if (dout_1 !== e) begin
                        errors++;
                        $display("FAIL sb_pop1 got %h expected %h", dout_1, e);
                    end
                end
            end
            if (dout_0_valid && dout_0_ready) begin
                checks++;
                if (exp0.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop0 got %h expected nothing", dout_0);
                end else begin
                    e = exp0.pop_front();
                    if (dout_0 !== e) begin
                        errors++;
                        $display("FAIL sb_pop0 got %h expected %h", dout_0, e);
                    end
                end
            end
            if (din_valid && din_ready) begin
                if (select) exp1.push_back(din);
                else        exp0.push_back(din);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        din_valid    = 1'b0;
        dout_1_ready = 1'b0;
        dout_0_ready = 1'b0;
    endtask

    task automatic drain();
        din_valid    = 1'b0;
        dout_1_ready = 1'b1;
        dout_0_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        din = '0;
        select = 1'b0;
        idle();
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (din_ready !== 1'b1 || count_1 !== 0 || count_0 !== 0) begin
            errors++;
            $display("FAIL reset_init got rdy=%b c1=%0d c0=%0d required 1 0 0",
                     din_ready, count_1, count_0);
        end
        din = 32'hDEAD_BEEF;
        select = 1'b1;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        #2;
        reset = 1'b1;
        exp1.delete();
        exp0.delete();
        #1;
        checks++;
        if (dout_1 !== '0 || dout_1_valid !== 1'b0 || count_1 !== 0) begin
            errors++;
            $display("FAIL reset_async got d1=%h v1=%b c1=%0d required 0 0 0",
                     dout_1, dout_1_valid, count_1);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        checks++;
        if (din_ready !== 1'b1 || count_1 !== 0 || count_0 !== 0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b c1=%0d c0=%0d required 1 0 0",
                     din_ready, count_1, count_0);
        end
    endtask

    task automatic test_steering();
        idle();
        din = 32'hAAAA_0001;
        select = 1'b1;
        din_valid = 1'b1;
        step();
        checks++;
        if (dout_1 !== 32'hAAAA_0001 || dout_1_valid !== 1'b1) begin
            errors++;
            $display("FAIL steer_1 got %h v=%b required aaaa0001 v=1",
                     dout_1, dout_1_valid);
        end
        din = 32'h5555_0000;
        select = 1'b0;
        step();
        din_valid = 1'b0;
        checks++;
        if (dout_0 !== 32'h5555_0000 || dout_0_valid !== 1'b1) begin
            errors++;
            $display("FAIL steer_0 got %h v=%b required 55550000 v=1",
                     dout_0, dout_0_valid);
        end
        checks++;
        if (count_1 !== 1 || count_0 !== 1 || dout_1 !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL steer_counts got c1=%0d c0=%0d d1=%h required 1 1 aaaa0001",
                     count_1, count_0, dout_1);
        end
        drain();
    endtask

    task automatic test_backpressure();
        idle();
        select = 1'b1;
        din_valid = 1'b1;
        din = 32'h10;
        step();
        din = 32'h11;
        step();
        din = 32'h12;
        #1;
        checks++;
        if (count_1 !== 2 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got c1=%0d rdy=%b required 2 0", count_1, din_ready);
        end
        step();
        checks++;
        if (count_1 !== 2 || dout_1 !== 32'h10) begin
            errors++;
            $display("FAIL bp_hold got c1=%0d d1=%h required 2 10", count_1, dout_1);
        end
        select = 1'b0;
        #1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_switch got rdy=%b required 1", din_ready);
        end
        step();
        din_valid = 1'b0;
        checks++;
        if (count_0 !== 1 || dout_0 !== 32'h12 || count_1 !== 2) begin
            errors++;
            $display("FAIL bp_land0 got c0=%0d d0=%h c1=%0d required 1 12 2",
                     count_0, dout_0, count_1);
        end
        dout_1_ready = 1'b1;
        step();
        checks++;
        if (dout_1 !== 32'h11 || count_1 !== 1) begin
            errors++;
            $display("FAIL bp_pop got d1=%h c1=%0d required 11 1", dout_1, count_1);
        end
        step();
        checks++;
        if (count_1 !== 0 || dout_1_valid !== 1'b0 || dout_1 !== '0) begin
            errors++;
            $display("FAIL bp_empty got c1=%0d v1=%b d1=%h required 0 0 0",
                     count_1, dout_1_valid, dout_1);
        end
        drain();
    endtask

    task automatic test_push_pop();
        idle();
        select = 1'b0;
        din = 32'h20;
        din_valid = 1'b1;
        step();
        din = 32'h21;
        dout_0_ready = 1'b1;
        step();
        idle();
        checks++;
        if (count_0 !== 1 || dout_0 !== 32'h21) begin
            errors++;
            $display("FAIL push_pop got c0=%0d d0=%h required 1 21", count_0, dout_0);
        end
        drain();
    endtask

    task automatic test_wrap();
        idle();
        select = 1'b1;
        dout_1_ready = 1'b1;
        din_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = 32'h30 + 32'(i);
            step();
            checks++;
            if (count_1 > 1) begin
                errors++;
                $display("FAIL wrap_count[%0d] got %0d required <=1", i, count_1);
            end
        end
        din_valid = 1'b0;
        step();
        idle();
        checks++;
        if (count_1 !== 0 || exp1.size() != 0) begin
            errors++;
            $display("FAIL wrap_done got c1=%0d pending=%0d required 0 0",
                     count_1, exp1.size());
        end
    endtask

    task automatic test_reset_mid();
        idle();
        din_valid = 1'b1;
        select = 1'b1;
        din = 32'h41;
        step();
        din = 32'h42;
        step();
        select = 1'b0;
        din = 32'h43;
        step();
        din_valid = 1'b0;
        checks++;
        if (count_1 !== 2 || count_0 !== 1) begin
            errors++;
            $display("FAIL mid_fill got c1=%0d c0=%0d required 2 1", count_1, count_0);
        end
        reset = 1'b1;
        exp1.delete();
        exp0.delete();
        #1;
        checks++;
        if (count_1 !== 0 || count_0 !== 0 || dout_1_valid !== 1'b0 ||
            dout_0_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got c1=%0d c0=%0d v1=%b v0=%b required 0 0 0 0",
                     count_1, count_0, dout_1_valid, dout_0_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        dout_1_ready = 1'b1;
        dout_0_ready = 1'b1;
        step();
        step();
        checks++;
        if (dout_1_valid !== 1'b0 || dout_0_valid !== 1'b0 ||
            dout_1 !== '0 || dout_0 !== '0) begin
            errors++;
            $display("FAIL mid_stale got v1=%b v0=%b d1=%h d0=%h required 0 0 0 0",
                     dout_1_valid, dout_0_valid, dout_1, dout_0);
        end
        idle();
        select = 1'b1;
        din = 32'h50;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        checks++;
        if (dout_1 !== 32'h50 || count_1 !== 1) begin
            errors++;
            $display("FAIL mid_restart got d1=%h c1=%0d required 50 1", dout_1, count_1);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_steering();
        test_backpressure();
        test_push_pop();
        test_wrap();
        test_reset_mid();
        checks++;
        if (exp1.size() != 0 || exp0.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got q1=%0d q0=%0d required 0 0",
                     exp1.size(), exp0.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
